// File: rtl/pad_arb_pkg.sv
// Shared types and helpers for the pad bank arbiter.
package pad_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StTurn  = 2'd1,
      StOwned = 2'd2
   } arb_state_e;

   localparam int unsigned PadWDefault = 16;

   // Index width for a requester vector of n entries, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first asserted request at or after the pointer,
// wrapping modulo NumReq.
module rr_picker
   import pad_arb_pkg::*;
#(
   parameter int unsigned NumReq = 4,
   parameter int unsigned IdxW   = idx_width(NumReq)
) (
   input  logic [NumReq-1:0] i_req,
   input  logic [IdxW-1:0]   i_ptr,
   output logic              o_valid,
   output logic [IdxW-1:0]   o_idx
);

   int unsigned w_pos;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_pos   = 0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= NumReq) begin
            w_pos = w_pos - NumReq;
         end
         if (!o_valid && i_req[w_pos]) begin
            o_valid = 1'b1;
            o_idx   = IdxW'(w_pos);
         end
      end
   end

endmodule

// File: rtl/pad_bank_arbiter.sv
// Round-robin owner of the shared IO pad bank with a tristated turnaround gap between owners.
// Forced handover after MAX_HOLD owned cycles is built only when PAD_ARB_TIMEOUT_EN is defined.
module pad_bank_arbiter
   import pad_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned PAD_W       = PadWDefault,
   parameter int unsigned TURN_CYCLES = 2,
   parameter int unsigned MAX_HOLD    = 256
) (
   input  logic                             sys_clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ*PAD_W-1:0]         req_pad_o,
   input  logic [NUM_REQ*PAD_W-1:0]         req_pad_oe,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [NUM_REQ-1:0]               preempt,
   output logic [idx_width(NUM_REQ)-1:0]    owner,
   output logic                             busy,
   input  logic [PAD_W-1:0]                 io_pad_i,
   output logic [PAD_W-1:0]                 req_pad_i,
   output logic [PAD_W-1:0]                 io_pad_o,
   output logic [PAD_W-1:0]                 io_pad_oe
);

   localparam int unsigned IdxW  = idx_width(NUM_REQ);
   localparam int unsigned TurnW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [TurnW-1:0]   TurnInit = TurnW'(TURN_CYCLES - 1);
   localparam logic [IdxW-1:0]    LastIdx  = IdxW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] OneHot0  = NUM_REQ'(1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TURN_CYCLES < 1 || MAX_HOLD < 2) begin : g_param_check
      $error("pad_bank_arbiter: parameter out of range");
   end

   arb_state_e           r_state, w_state_d;
   logic [IdxW-1:0]      r_owner, w_owner_d;
   logic [IdxW-1:0]      r_ptr, w_ptr_d;
   logic [TurnW-1:0]     r_turn_cnt, w_turn_cnt_d;
   logic [NUM_REQ-1:0]   r_gnt, w_gnt_d;

   logic                 w_pick_valid;
   logic [IdxW-1:0]      w_pick_idx;
   logic                 w_owner_req;
   logic                 w_owned;

`ifdef PAD_ARB_TIMEOUT_EN
   localparam int unsigned HoldW = $clog2(MAX_HOLD);
   localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

   logic [HoldW-1:0]     r_hold, w_hold_d;
   logic [NUM_REQ-1:0]   r_preempt, w_preempt_d;
   logic [NUM_REQ-1:0]   w_owner_oh;
   logic                 w_others;

   assign w_owner_oh = OneHot0 << r_owner;
   assign w_others   = |(req & ~w_owner_oh);
`endif

   rr_picker #(
      .NumReq (NUM_REQ),
      .IdxW   (IdxW)
   ) u_rr_picker (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   assign w_owner_req = req[r_owner];

   always_comb begin
      w_state_d    = r_state;
      w_owner_d    = r_owner;
      w_ptr_d      = r_ptr;
      w_turn_cnt_d = r_turn_cnt;
`ifdef PAD_ARB_TIMEOUT_EN
      w_hold_d     = r_hold;
      w_preempt_d  = '0;
`endif
      unique case (r_state)
         StIdle: begin
            if (w_pick_valid) begin
               w_state_d    = StTurn;
               w_owner_d    = w_pick_idx;
               w_turn_cnt_d = TurnInit;
            end
         end
         StTurn: begin
            if (r_turn_cnt == '0) begin
               // The candidate must still want the pads once the gap has elapsed.
               if (w_owner_req) begin
                  w_state_d = StOwned;
                  w_ptr_d   = (r_owner == LastIdx) ? '0 : r_owner + 1'b1;
`ifdef PAD_ARB_TIMEOUT_EN
                  w_hold_d  = '0;
`endif
               end else begin
                  w_state_d = StIdle;
               end
            end else begin
               w_turn_cnt_d = r_turn_cnt - 1'b1;
            end
         end
         StOwned: begin
            if (!w_owner_req) begin
               if (w_pick_valid) begin
                  w_state_d    = StTurn;
                  w_owner_d    = w_pick_idx;
                  w_turn_cnt_d = TurnInit;
               end else begin
                  w_state_d = StIdle;
               end
            end
`ifdef PAD_ARB_TIMEOUT_EN
            // Pointer already sits past the owner, so the pick lands on another requester.
            else if (r_hold == HoldMax && w_others) begin
               w_preempt_d  = w_owner_oh;
               w_state_d    = StTurn;
               w_owner_d    = w_pick_idx;
               w_turn_cnt_d = TurnInit;
            end else if (r_hold != HoldMax) begin
               w_hold_d = r_hold + 1'b1;
            end
`endif
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
      w_gnt_d = (w_state_d == StOwned) ? (OneHot0 << w_owner_d) : '0;
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_owner    <= '0;
         r_ptr      <= '0;
         r_turn_cnt <= '0;
         r_gnt      <= '0;
      end else begin
         r_state    <= w_state_d;
         r_owner    <= w_owner_d;
         r_ptr      <= w_ptr_d;
         r_turn_cnt <= w_turn_cnt_d;
         r_gnt      <= w_gnt_d;
      end
   end

`ifdef PAD_ARB_TIMEOUT_EN
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_hold    <= '0;
         r_preempt <= '0;
      end else begin
         r_hold    <= w_hold_d;
         r_preempt <= w_preempt_d;
      end
   end

   assign preempt = r_preempt;
`else
   assign preempt = '0;
`endif

   assign gnt   = r_gnt;
   assign owner = r_owner;
   assign busy  = (r_state != StIdle);

   // Reset gates the pads directly so they release without waiting for the state to settle.
   assign w_owned   = (r_state == StOwned) && !rst;
   assign io_pad_o  = w_owned ? req_pad_o[PAD_W*r_owner +: PAD_W]  : '0;
   assign io_pad_oe = w_owned ? req_pad_oe[PAD_W*r_owner +: PAD_W] : '0;
   assign req_pad_i = io_pad_i;

   a_gnt_onehot: assert property (@(posedge sys_clk) disable iff (rst) $onehot0(gnt));
   a_oe_owned: assert property (@(posedge sys_clk) disable iff (rst)
                                (r_state != StOwned) |-> (io_pad_oe == '0));

endmodule

// File: tb/tb_pad_bank_arbiter.sv
// Self-checking bench for pad_bank_arbiter: vector table, hand sequences and random traffic
// against a cycle-level reference model.
`timescale 1ns/1ps
module tb_pad_bank_arbiter;

   localparam int NReq   = 4;
   localparam int PadW   = 16;
   localparam int Turn   = 2;
   localparam int MaxHold = 8;
`ifdef PAD_ARB_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
   localparam int RelCycles = 6;
`else
   localparam bit TimeoutEn = 1'b0;
   localparam int RelCycles = 10;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NReq-1:0]      req;
   logic [NReq*PadW-1:0] req_pad_o;
   logic [NReq*PadW-1:0] req_pad_oe;
   logic [NReq-1:0]      gnt;
   logic [NReq-1:0]      preempt;
   logic [1:0]           owner;
   logic                 busy;
   logic [PadW-1:0]      io_pad_i;
   logic [PadW-1:0]      req_pad_i;
   logic [PadW-1:0]      io_pad_o;
   logic [PadW-1:0]      io_pad_oe;

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   pad_bank_arbiter #(
      .NUM_REQ     (NReq),
      .PAD_W       (PadW),
      .TURN_CYCLES (Turn),
      .MAX_HOLD    (MaxHold)
   ) dut (
      .sys_clk    (clk),
      .rst        (rst),
      .req        (req),
      .req_pad_o  (req_pad_o),
      .req_pad_oe (req_pad_oe),
      .gnt        (gnt),
      .preempt    (preempt),
      .owner      (owner),
      .busy       (busy),
      .io_pad_i   (io_pad_i),
      .req_pad_i  (req_pad_i),
      .io_pad_o   (io_pad_o),
      .io_pad_oe  (io_pad_oe)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 = idle, 1 = tristated gap, 2 = owned
   int         m_phase, m_owner, m_ptr, m_gap_left, m_held;
   logic [3:0] m_pre;

   function automatic int rr_pick(input logic [3:0] r, input int from);
      for (int k = 0; k < NReq; k++) begin
         int c;
         c = (from + k) % NReq;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_owner = 0; m_ptr = 0; m_gap_left = 0; m_held = 0; m_pre = '0;
   endtask

   task automatic model_step(input logic [3:0] r);
      int  p;
      bit  others;
      m_pre  = '0;
      p      = rr_pick(r, m_ptr);
      others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
      case (m_phase)
         0: if (p >= 0) begin
               m_phase = 1; m_owner = p; m_gap_left = Turn;
            end
         1: begin
               m_gap_left = m_gap_left - 1;
               if (m_gap_left == 0) begin
                  if (r[m_owner]) begin
                     m_phase = 2; m_held = 1; m_ptr = (m_owner + 1) % NReq;
                  end else begin
                     m_phase = 0;
                  end
               end
            end
         default: begin
            if (!r[m_owner]) begin
               if (p >= 0) begin
                  m_phase = 1; m_owner = p; m_gap_left = Turn;
               end else begin
                  m_phase = 0;
               end
            end else if (TimeoutEn && m_held >= MaxHold && others) begin
               m_pre[m_owner] = 1'b1;
               m_phase = 1; m_owner = p; m_gap_left = Turn;
            end else begin
               m_held = m_held + 1;
            end
         end
      endcase
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step(req);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            logic [3:0]  e_gnt;
            logic [15:0] e_o, e_oe;
            e_gnt = (m_phase == 2) ? (4'b0001 << m_owner) : 4'b0000;
            e_o   = (m_phase == 2) ? req_pad_o[m_owner*PadW +: PadW]  : 16'h0;
            e_oe  = (m_phase == 2) ? req_pad_oe[m_owner*PadW +: PadW] : 16'h0;
            chk("mon_gnt", 32'(gnt), 32'(e_gnt));
            chk("mon_preempt", 32'(preempt), 32'(m_pre));
            chk("mon_owner", 32'(owner), 32'(m_owner));
            chk("mon_busy", 32'(busy), 32'(m_phase != 0));
            chk("mon_pad_o", 32'(io_pad_o), 32'(e_o));
            chk("mon_pad_oe", 32'(io_pad_oe), 32'(e_oe));
            chk("mon_pad_i", 32'(req_pad_i), 32'(io_pad_i));
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_gnt(input logic [3:0] g, input int budget, input string name);
      int n = 0;
      while (gnt !== g && n < budget) begin
         tick();
         n++;
      end
      chk(name, 32'(gnt), 32'(g));
   endtask

   typedef struct packed {
      logic [3:0]  req;
      logic [3:0]  gnt;
      logic        busy;
      logic [1:0]  owner;
      logic [15:0] oe;
      logic [15:0] o;
   } vec_t;

   vec_t vecs [9];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int         order[$];
      int         gaps[$];
      int         cnt[4];
      int         exp_order[5];
      int         gap, n, idx;
      logic [3:0] drop, prev, pre_seen;

      rst        = 1'b1;
      req        = '0;
      io_pad_i   = 16'h5A3C;
      req_pad_o  = {16'h3333, 16'h2222, 16'h1111, 16'hA5A5};
      req_pad_oe = {16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFFFF};

      vecs[0] = '{4'b0001, 4'b0000, 1'b1, 2'd0, 16'h0000, 16'h0000};
      vecs[1] = '{4'b0001, 4'b0000, 1'b1, 2'd0, 16'h0000, 16'h0000};
      vecs[2] = '{4'b0001, 4'b0001, 1'b1, 2'd0, 16'hFFFF, 16'hA5A5};
      vecs[3] = '{4'b0001, 4'b0001, 1'b1, 2'd0, 16'hFFFF, 16'hA5A5};
      vecs[4] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000, 16'h0000};
      vecs[5] = '{4'b0001, 4'b0000, 1'b1, 2'd0, 16'h0000, 16'h0000};
      vecs[6] = '{4'b0000, 4'b0000, 1'b1, 2'd0, 16'h0000, 16'h0000};
      vecs[7] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000, 16'h0000};
      vecs[8] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000, 16'h0000};

      // Reset state
      repeat (3) tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_preempt", 32'(preempt), 32'h0);
      chk("rst_oe", 32'(io_pad_oe), 32'h0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Grant latency, release, and a one-cycle request pulse that dies in the gap
      for (int v = 0; v < 9; v++) begin
         req = vecs[v].req;
         tick();
         chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].gnt));
         chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
         chk($sformatf("vec%0d_owner", v), 32'(owner), 32'(vecs[v].owner));
         chk($sformatf("vec%0d_oe", v), 32'(io_pad_oe), 32'(vecs[v].oe));
         chk($sformatf("vec%0d_o", v), 32'(io_pad_o), 32'(vecs[v].o));
      end

      // All four requesting, each releasing after RelCycles owned cycles
      do_reset();
      req  = 4'b1111;
      gap  = 0;
      prev = '0;
      drop = '0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int c = 0; c < 400 && order.size() < 5; c++) begin
         tick();
         req  = req | drop;
         drop = '0;
         if (gnt != 4'b0000) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
            if (prev == 4'b0000) begin
               order.push_back(idx);
               gaps.push_back(gap);
               gap = 0;
            end
            cnt[idx]++;
            if (cnt[idx] % RelCycles == 0) begin
               req[idx]  = 1'b0;
               drop[idx] = 1'b1;
            end
         end else begin
            gap++;
            chk("gap_oe", 32'(io_pad_oe), 32'h0);
         end
         prev = gnt;
      end
      req = '0;
      exp_order = '{0, 1, 2, 3, 0};
      chk("rr_order_len", 32'(order.size()), 32'd5);
      for (int i = 0; i < order.size() && i < 5; i++) begin
         chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
         chk($sformatf("rr_gap%0d", i), 32'(gaps[i]), 32'(Turn));
      end
      repeat (4) tick();

      // Hold behaviour with a competing requester
      req = 4'b0001;
      wait_gnt(4'b0001, 8, "hold_first_gnt");
      req = 4'b0101;
`ifdef PAD_ARB_TIMEOUT_EN
      n = 1;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (gnt == 4'b0001) n++;
         else break;
      end
      chk("to_owned_cycles", 32'(n), 32'(MaxHold));
      chk("to_preempt_pulse", 32'(preempt), 32'b0001);
      chk("to_gnt_drop", 32'(gnt), 32'b0000);
      tick();
      chk("to_preempt_clear", 32'(preempt), 32'b0000);
      chk("to_gap_gnt", 32'(gnt), 32'b0000);
      tick();
      chk("to_next_gnt", 32'(gnt), 32'b0100);
      req = 4'b0001;
      tick();
      wait_gnt(4'b0001, 5, "to_reserve_gnt");
      // req0 drops on the exact timeout edge: plain release, no preempt
      req = 4'b0101;
      repeat (MaxHold - 1) tick();
      chk("to_edge_still_owned", 32'(gnt), 32'b0001);
      req = 4'b0100;
      tick();
      chk("to_edge_no_preempt", 32'(preempt), 32'b0000);
      chk("to_edge_gnt_drop", 32'(gnt), 32'b0000);
      tick();
      chk("to_edge_gap", 32'(gnt), 32'b0000);
      tick();
      chk("to_edge_handover", 32'(gnt), 32'b0100);
`else
      n        = 0;
      pre_seen = '0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (gnt == 4'b0001) n++;
         pre_seen = pre_seen | preempt;
      end
      chk("hold_cycles", 32'(n), 32'd40);
      chk("hold_no_preempt", 32'(pre_seen), 32'h0);
      req = 4'b0100;
      tick();
      chk("hold_release_gnt", 32'(gnt), 32'b0000);
      tick();
      tick();
      chk("hold_handover", 32'(gnt), 32'b0100);
`endif
      req = '0;
      repeat (4) tick();

      // Asynchronous reset while owned
      req = 4'b0001;
      wait_gnt(4'b0001, 8, "arst_pre_gnt");
      chk("arst_pre_oe", 32'(io_pad_oe), 32'hFFFF);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_gnt", 32'(gnt), 32'h0);
      chk("arst_oe", 32'(io_pad_oe), 32'h0);
      chk("arst_o", 32'(io_pad_o), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      req = 4'b0010;
      tick();
      rst = 1'b0;
      tick();
      chk("arst_owner", 32'(owner), 32'd1);
      chk("arst_busy_after", 32'(busy), 32'd1);
      req = '0;
      repeat (4) tick();

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NReq; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         end
         req_pad_o  = {$urandom, $urandom};
         req_pad_oe = {$urandom, $urandom};
         io_pad_i   = 16'($urandom);
         tick();
      end

      req = '0;
      repeat (6) tick();
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
